// File: rtl/isqrt_seq_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | isqrt_pkg : shared types/constants for isqrt_seq_fsm                      |
// | Build option: ISQRT_SEQ_FAST_EN selects two steps per cycle.              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package isqrt_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int ISQRT_X_W   = 32;
  localparam int ISQRT_Y_W   = 16;
  localparam int ISQRT_REM_W = 18;

`ifdef ISQRT_SEQ_FAST_EN
  localparam int ISQRT_SPC     = 2;
  localparam int ISQRT_LATENCY = 8;
  localparam int ISQRT_CNT_W   = 3;
`else
  localparam int ISQRT_SPC     = 1;
  localparam int ISQRT_LATENCY = 16;
  localparam int ISQRT_CNT_W   = 4;
`endif

endpackage
`default_nettype wire

// File: rtl/isqrt_seq_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | isqrt_seq_fsm_if : request/result handshake bundle for isqrt_seq_fsm      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface isqrt_seq_fsm_if;
  import isqrt_pkg::*;

  logic                 x_vld;
  logic [ISQRT_X_W-1:0] x;
  logic                 y_vld;
  logic [ISQRT_Y_W-1:0] y;
  logic                 busy;
  logic                 ovf;

  modport master (output x_vld, x, input y_vld, y, busy, ovf);
  modport slave  (input x_vld, x, output y_vld, y, busy, ovf);
endinterface
`default_nettype wire

// File: rtl/isqrt_seq_fsm_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | isqrt_step : one combinational digit-by-digit square-root step            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [ISQRT_REM_W-1:0] rem,
  input  logic [ISQRT_Y_W-1:0]   root,
  input  logic [1:0]             pair,
  output logic [ISQRT_REM_W-1:0] rem_nxt,
  output logic [ISQRT_Y_W-1:0]   root_nxt
);

  logic [ISQRT_REM_W-1:0] acc;
  logic [ISQRT_REM_W-1:0] trial;
  logic                   ge;

  // Remainder stays below 2*root+1, so the dropped top bits are always zero.
  assign acc      = {rem[ISQRT_REM_W-3:0], pair};
  assign trial    = {root, 2'b01};
  assign ge       = (acc >= trial);
  assign rem_nxt  = ge ? (acc - trial) : acc;
  assign root_nxt = {root[ISQRT_Y_W-2:0], ge};

endmodule
`default_nettype wire

// File: rtl/isqrt_seq_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | isqrt_seq_fsm : sequential floor(sqrt(x)), 32-bit in / 16-bit out         |
// | ISQRT_SEQ_FAST_EN defined: two steps per cycle (latency 8, else 16).      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module isqrt_seq_fsm
  import isqrt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  isqrt_seq_fsm_if.slave  bus
);

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_BUSY = ST_BUSY;
  localparam int         SHIFT  = 2 * ISQRT_SPC;
  localparam logic [ISQRT_CNT_W-1:0] CNT_LAST = ISQRT_CNT_W'(ISQRT_Y_W / ISQRT_SPC - 1);

  logic [0:0]             state;
  logic [ISQRT_CNT_W-1:0] cnt;
  logic [ISQRT_REM_W-1:0] rem_r;
  logic [ISQRT_Y_W-1:0]   root_r;
  logic [ISQRT_X_W-1:0]   sh;
  logic [ISQRT_Y_W-1:0]   y_r;
  logic                   y_vld_r;
  logic                   ovf_r;

  logic                   idle;
  logic [ISQRT_X_W-1:0]   src;
  logic [ISQRT_REM_W-1:0] rem_src;
  logic [ISQRT_Y_W-1:0]   root_src;
  logic [ISQRT_REM_W-1:0] rem0;
  logic [ISQRT_Y_W-1:0]   root0;
  logic [ISQRT_REM_W-1:0] rem_nxt;
  logic [ISQRT_Y_W-1:0]   root_nxt;

  // In IDLE the first step works straight off the incoming radicand.
  assign idle     = (state == S_IDLE);
  assign src      = idle ? bus.x : sh;
  assign rem_src  = idle ? '0 : rem_r;
  assign root_src = idle ? '0 : root_r;

  isqrt_step u_step0 (
    .rem      (rem_src),
    .root     (root_src),
    .pair     (src[ISQRT_X_W-1 -: 2]),
    .rem_nxt  (rem0),
    .root_nxt (root0)
  );

  if (ISQRT_SPC == 2) begin : g_fast
    logic [ISQRT_REM_W-1:0] rem1;
    logic [ISQRT_Y_W-1:0]   root1;

    isqrt_step u_step1 (
      .rem      (rem0),
      .root     (root0),
      .pair     (src[ISQRT_X_W-3 -: 2]),
      .rem_nxt  (rem1),
      .root_nxt (root1)
    );

    assign rem_nxt  = rem1;
    assign root_nxt = root1;
  end else begin : g_single
    assign rem_nxt  = rem0;
    assign root_nxt = root0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem_r   <= '0;
      root_r  <= '0;
      sh      <= '0;
      y_r     <= '0;
      y_vld_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      y_vld_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.x_vld) begin
            state  <= S_BUSY;
            cnt    <= ISQRT_CNT_W'(1);
            rem_r  <= rem_nxt;
            root_r <= root_nxt;
            sh     <= bus.x << SHIFT;
          end
        end
        S_BUSY: begin
          rem_r  <= rem_nxt;
          root_r <= root_nxt;
          sh     <= sh << SHIFT;
          cnt    <= cnt + ISQRT_CNT_W'(1);
          if (bus.x_vld) begin
            ovf_r <= 1'b1;
          end
          if (cnt == CNT_LAST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            y_r     <= root_nxt;
            y_vld_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.y     = y_r;
  assign bus.y_vld = y_vld_r;
  assign bus.busy  = (state == S_BUSY);
  assign bus.ovf   = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_seq_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_isqrt_seq_fsm : directed-vector bench for isqrt_seq_fsm                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_isqrt_seq_fsm;
  import isqrt_pkg::*;

  typedef struct {
    logic [31:0] x;
    logic [15:0] y;
  } vec_t;

  localparam int NVEC    = 15;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs [NVEC];

  isqrt_seq_fsm_if bus ();

  isqrt_seq_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a one-cycle request; returns #1 after the accepting edge.
  task automatic start(input logic [31:0] xv);
    @(negedge clk);
    bus.x_vld = 1'b1;
    bus.x     = xv;
    @(posedge clk);
    #1;
    bus.x_vld = 1'b0;
  endtask

  // lat = index of the cycle after acceptance that is currently being sampled.
  task automatic wait_result(input int first, output int lat);
    lat = first;
    while (bus.y_vld !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic logic [15:0] ref_isqrt(input logic [31:0] xv);
    logic [15:0] r;
    logic [15:0] cand;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      cand = r | (16'd1 << b);
      if ({32'd0, cand} * {32'd0, cand} <= {32'd0, xv}) r = cand;
    end
    return r;
  endfunction

  initial begin
    int lat;
    int seen;
    logic [31:0] rx;

    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{32'd0,          16'd0};
    vecs[1]  = '{32'd15,         16'd3};
    vecs[2]  = '{32'd16,         16'd4};
    vecs[3]  = '{32'hFFFF_FFFF,  16'hFFFF};
    vecs[4]  = '{32'd1000000,    16'd1000};
    vecs[5]  = '{32'hFFFE_0001,  16'hFFFF};
    vecs[6]  = '{32'd1,          16'd1};
    vecs[7]  = '{32'd2,          16'd1};
    vecs[8]  = '{32'd3,          16'd1};
    vecs[9]  = '{32'd99,         16'd9};
    vecs[10] = '{32'h8000_0000,  16'd46340};
    vecs[11] = '{32'h4000_0000,  16'd32768};
    vecs[12] = '{32'd65535,      16'd255};
    vecs[13] = '{32'hFFFF_FFFE,  16'hFFFF};
    vecs[14] = '{32'hFFFE_0000,  16'hFFFE};

    rst       = 1'b1;
    bus.x_vld = 1'b0;
    bus.x     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_y_vld", {31'd0, bus.y_vld}, 32'd0);
    check("reset_y",     {16'd0, bus.y},     32'd0);
    check("reset_busy",  {31'd0, bus.busy},  32'd0);
    check("reset_ovf",   {31'd0, bus.ovf},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      start(vecs[i].x);
      check($sformatf("busy_after_accept[%0d]", i), {31'd0, bus.busy}, 32'd1);
      wait_result(1, lat);
      check($sformatf("latency[%0d]", i), lat, ISQRT_LATENCY);
      check($sformatf("y[%0d]", i), {16'd0, bus.y}, {16'd0, vecs[i].y});
      check($sformatf("idle_at_result[%0d]", i), {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("y_vld_pulse[%0d]", i), {31'd0, bus.y_vld}, 32'd0);
      check($sformatf("y_hold[%0d]", i), {16'd0, bus.y}, {16'd0, vecs[i].y});
    end

    for (int i = 0; i < 100; i++) begin
      rx = $urandom;
      if (i < 50) rx = rx >> $urandom_range(0, 31);
      start(rx);
      wait_result(1, lat);
      check($sformatf("rand_lat[%0d]", i), lat, ISQRT_LATENCY);
      check($sformatf("rand_y[%0d] x=0x%0h", i, rx), {16'd0, bus.y}, {16'd0, ref_isqrt(rx)});
    end

    // Back-to-back: new request in the result cycle.
    start(32'd49);
    wait_result(1, lat);
    check("b2b_first_y", {16'd0, bus.y}, 32'd7);
    bus.x_vld = 1'b1;
    bus.x     = 32'd81;
    @(posedge clk);
    #1;
    bus.x_vld = 1'b0;
    check("b2b_accepted_busy", {31'd0, bus.busy}, 32'd1);
    wait_result(1, lat);
    check("b2b_second_lat", lat, ISQRT_LATENCY);
    check("b2b_second_y", {16'd0, bus.y}, 32'd9);
    check("b2b_ovf", {31'd0, bus.ovf}, 32'd0);

    // Reset mid-computation aborts it.
    start(32'd100);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #2;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.y_vld === 1'b1) seen = 1;
    end
    check("abort_no_y_vld", seen, 0);
    check("abort_y", {16'd0, bus.y}, 32'd0);
    start(32'd4);
    wait_result(1, lat);
    check("after_abort_lat", lat, ISQRT_LATENCY);
    check("after_abort_y", {16'd0, bus.y}, 32'd2);

    // Request while BUSY is dropped and flags overflow.
    start(32'd200);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.x_vld = 1'b1;
    bus.x     = 32'd9;
    @(posedge clk);
    #1;
    bus.x_vld = 1'b0;
    check("drop_ovf", {31'd0, bus.ovf}, 32'd1);
    wait_result(6, lat);
    check("drop_lat", lat, ISQRT_LATENCY);
    check("drop_y", {16'd0, bus.y}, 32'd14);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.y_vld === 1'b1) seen = 1;
    end
    check("drop_no_extra_result", seen, 0);
    check("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    rst = 1'b1;
    #2;
    check("ovf_cleared", {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
